// File: rtl/skeleton_cpu_if.sv
// skeleton_cpu_if: memory-side bus of the skeleton_cpu core.
//   address_imem : word address of the current instruction (PC)
//   q_imem       : instruction word, combinational for address_imem
//   address_dmem : data word address
//   data         : store data for sw
//   wren         : data memory write enable
//   q_dmem       : load data, combinational for address_dmem
// The core uses the master modport. The memory side uses the slave modport.
interface skeleton_cpu_if;
  logic [11:0] address_imem;
  logic [31:0] q_imem;
  logic [11:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;

  modport master (
    output address_imem,
    output address_dmem,
    output data,
    output wren,
    input  q_imem,
    input  q_dmem
  );

  modport slave (
    input  address_imem,
    input  address_dmem,
    input  data,
    input  wren,
    output q_imem,
    output q_dmem
  );
endinterface

// File: rtl/skeleton_cpu.sv
// skeleton_cpu: single-cycle 32-bit core (PC, decoder, ALU, branch/jump, 32x32 register file).
// Every instruction is fetched, executed and retired within one clock.
// Ports:
//   clock  : sole clock; all state updates on the rising edge
//   reset  : asynchronous, active-low
//   bus    : skeleton_cpu_if.master (instruction and data memory)
// Optional macro SKELETON_DEBUG_EN adds these ports:
//   ctrl_writeEnable, ctrl_writeReg, data_writeReg : view of the register write port
module skeleton_cpu (
  input  logic           clock,
  input  logic           reset,
  skeleton_cpu_if.master bus
`ifdef SKELETON_DEBUG_EN
  ,
  output logic           ctrl_writeEnable,
  output logic [4:0]     ctrl_writeReg,
  output logic [31:0]    data_writeReg
`endif
);

  localparam logic [4:0] OpRType = 5'b00000;
  localparam logic [4:0] OpJ     = 5'b00001;
  localparam logic [4:0] OpBne   = 5'b00010;
  localparam logic [4:0] OpJal   = 5'b00011;
  localparam logic [4:0] OpJr    = 5'b00100;
  localparam logic [4:0] OpAddi  = 5'b00101;
  localparam logic [4:0] OpBlt   = 5'b00110;
  localparam logic [4:0] OpSw    = 5'b00111;
  localparam logic [4:0] OpLw    = 5'b01000;
  localparam logic [4:0] OpSetx  = 5'b10101;
  localparam logic [4:0] OpBex   = 5'b10110;

  localparam logic [4:0] AluAdd  = 5'b00000;
  localparam logic [4:0] AluSub  = 5'b00001;
  localparam logic [4:0] AluAnd  = 5'b00010;
  localparam logic [4:0] AluOr   = 5'b00011;
  localparam logic [4:0] AluSll  = 5'b00100;
  localparam logic [4:0] AluSra  = 5'b00101;

  localparam logic [4:0] RegStatus = 5'd30;
  localparam logic [4:0] RegLink   = 5'd31;

  logic [11:0] pc_q, pc_d;
  logic [31:0] rf_q [32];

  // Instruction fields
  logic [31:0] instr;
  logic [4:0]  opcode, rd, rs, rt, shamt, aluop;
  logic [31:0] imm_n, imm_t;
  logic        unused_instr;

  assign instr        = bus.q_imem;
  assign opcode       = instr[31:27];
  assign rd           = instr[26:22];
  assign rs           = instr[21:17];
  assign rt           = instr[16:12];
  assign shamt        = instr[11:7];
  assign aluop        = instr[6:2];
  assign imm_n        = {{15{instr[16]}}, instr[16:0]};
  assign imm_t        = {5'b00000, instr[26:0]};
  assign unused_instr = ^instr[1:0];

  // r0 is never written, so its storage stays at the reset value of zero.
  logic [31:0] rd_val, rs_val, rt_val, status_val;
  assign rd_val     = rf_q[rd];
  assign rs_val     = rf_q[rs];
  assign rt_val     = rf_q[rt];
  assign status_val = rf_q[RegStatus];

  // ALU
  logic [31:0] sum, diff, sum_imm;
  logic        ovf_add, ovf_sub, ovf_addi;

  assign sum      = rs_val + rt_val;
  assign diff     = rs_val - rt_val;
  assign sum_imm  = rs_val + imm_n;
  assign ovf_add  = (rs_val[31] == rt_val[31]) && (sum[31] != rs_val[31]);
  assign ovf_sub  = (rs_val[31] != rt_val[31]) && (diff[31] != rs_val[31]);
  assign ovf_addi = (rs_val[31] == imm_n[31]) && (sum_imm[31] != rs_val[31]);

  logic [11:0] pc_plus1, pc_branch, pc_target;
  assign pc_plus1  = pc_q + 12'd1;
  assign pc_branch = pc_plus1 + imm_n[11:0];
  assign pc_target = instr[11:0];

  // Register write port
  logic        we;
  logic        we_eff;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        rd_nz;

  assign rd_nz = (rd != 5'd0);

  always_comb begin
    we    = 1'b0;
    waddr = rd;
    wdata = '0;
    pc_d  = pc_plus1;

    case (opcode)
      OpRType: begin
        case (aluop)
          AluAdd: begin
            // An overflow redirects the write to the status register. With rd = r0
            // the whole write is dropped, status included.
            we = rd_nz;
            if (ovf_add) begin
              waddr = RegStatus;
              wdata = 32'd1;
            end else begin
              wdata = sum;
            end
          end
          AluSub: begin
            we = rd_nz;
            if (ovf_sub) begin
              waddr = RegStatus;
              wdata = 32'd3;
            end else begin
              wdata = diff;
            end
          end
          AluAnd: begin
            we    = 1'b1;
            wdata = rs_val & rt_val;
          end
          AluOr: begin
            we    = 1'b1;
            wdata = rs_val | rt_val;
          end
          AluSll: begin
            we    = 1'b1;
            wdata = rs_val << shamt;
          end
          AluSra: begin
            we    = 1'b1;
            wdata = $signed(rs_val) >>> shamt;
          end
          default: ;
        endcase
      end
      OpAddi: begin
        we = rd_nz;
        if (ovf_addi) begin
          waddr = RegStatus;
          wdata = 32'd2;
        end else begin
          wdata = sum_imm;
        end
      end
      OpLw: begin
        we    = 1'b1;
        wdata = bus.q_dmem;
      end
      OpJ: pc_d = pc_target;
      OpJal: begin
        we    = 1'b1;
        waddr = RegLink;
        wdata = {20'd0, pc_plus1};
        pc_d  = pc_target;
      end
      OpJr: pc_d = rd_val[11:0];
      OpBne: begin
        if (rd_val != rs_val) pc_d = pc_branch;
      end
      OpBlt: begin
        if ($signed(rd_val) < $signed(rs_val)) pc_d = pc_branch;
      end
      OpSetx: begin
        we    = 1'b1;
        waddr = RegStatus;
        wdata = imm_t;
      end
      OpBex: begin
        if (status_val != 32'd0) pc_d = pc_target;
      end
      default: ;
    endcase
  end

  // Writes to r0 are dropped here, and the port is idle while reset is held.
  assign we_eff = we && (waddr != 5'd0) && reset;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q <= '0;
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      pc_q <= pc_d;
      if (we_eff) begin
        rf_q[waddr] <= wdata;
      end
    end
  end

  assign bus.address_imem = pc_q;
  assign bus.address_dmem = sum_imm[11:0];
  assign bus.data         = rd_val;
  assign bus.wren         = (opcode == OpSw) && reset;

`ifdef SKELETON_DEBUG_EN
  assign ctrl_writeEnable = we_eff;
  assign ctrl_writeReg    = waddr;
  assign data_writeReg    = wdata;
`endif

endmodule

// File: tb/tb_skeleton_cpu.sv
// Directed testbench for skeleton_cpu. It provides the instruction and data memories, runs short
// programs, and checks the PC sequence, the store port and the stored values.
module tb_skeleton_cpu;

  localparam int OpJ    = 1;
  localparam int OpBne  = 2;
  localparam int OpJal  = 3;
  localparam int OpJr   = 4;
  localparam int OpAddi = 5;
  localparam int OpBlt  = 6;
  localparam int OpSw   = 7;
  localparam int OpLw   = 8;
  localparam int OpSetx = 21;
  localparam int OpBex  = 22;

  logic clock;
  logic reset;
  skeleton_cpu_if bus ();

  logic [31:0] imem [4096];
  logic [31:0] dmem [4096];

  int n_cmp;
  int n_fail;

`ifdef SKELETON_DEBUG_EN
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
`endif

  skeleton_cpu dut (
    .clock            (clock),
    .reset            (reset),
    .bus              (bus)
`ifdef SKELETON_DEBUG_EN
    ,
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign bus.q_imem = imem[bus.address_imem];
  assign bus.q_dmem = dmem[bus.address_dmem];

  always @(posedge clock) begin
    if (bus.wren) dmem[bus.address_dmem] <= bus.data;
  end

  function automatic logic [31:0] enc_r(input int rd, input int rs, input int rt, input int sh,
                                        input int alu);
    return {5'd0, rd[4:0], rs[4:0], rt[4:0], sh[4:0], alu[4:0], 2'b00};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rd, input int rs, input int imm);
    return {op[4:0], rd[4:0], rs[4:0], imm[16:0]};
  endfunction

  function automatic logic [31:0] enc_j(input int op, input int t);
    return {op[4:0], t[26:0]};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 4096; i++) imem[i] = 32'd0;
  endtask

  // Ends one cycle into the program, with the instruction at address 0 on the bus.
  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    clear_imem();
    imem[0] = enc_i(OpSw, 5, 0, 0);
    imem[1] = enc_i(OpAddi, 5, 0, 9);
    imem[2] = enc_i(OpSw, 5, 0, 1);
    imem[3] = enc_j(OpJ, 3);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock);
      #1;
      n_cmp++;
      if (bus.address_imem !== 12'd0) begin
        n_fail++;
        $display("FAIL reset_pc: got %0d, want 0", bus.address_imem);
      end
      n_cmp++;
      if (bus.wren !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_wren: got %b, want 0", bus.wren);
      end
`ifdef SKELETON_DEBUG_EN
      n_cmp++;
      if (ctrl_writeEnable !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_dbg_we: got %b, want 0", ctrl_writeEnable);
      end
`endif
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.wren, bus.address_dmem, bus.data} !== {1'b1, 12'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_first_sw: got wren %b addr %0d data %h, want 1 0 0",
               bus.wren, bus.address_dmem, bus.data);
    end
    step(1);
    n_cmp++;
    if ({bus.address_imem, bus.wren} !== {12'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_pc1: got pc %0d wren %b, want 1 0", bus.address_imem, bus.wren);
    end
    step(1);
    n_cmp++;
    if ({bus.address_imem, bus.wren, bus.data} !== {12'd2, 1'b1, 32'd9}) begin
      n_fail++;
      $display("FAIL reset_pc2: got pc %0d wren %b data %h, want 2 1 9",
               bus.address_imem, bus.wren, bus.data);
    end
    // Assert reset in the middle of the sw cycle.
    #1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({bus.address_imem, bus.wren} !== {12'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_async: got pc %0d wren %b, want 0 0", bus.address_imem, bus.wren);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.wren, bus.data} !== {1'b1, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_regs_cleared: got wren %b data %h, want 1 0", bus.wren, bus.data);
    end
  endtask

  task automatic test_arith();
    int          addr [7];
    logic [31:0] want [7];
    clear_imem();
    imem[0]  = enc_i(OpAddi, 1, 0, 5);
    imem[1]  = enc_i(OpAddi, 2, 0, 7);
    imem[2]  = enc_r(3, 1, 2, 0, 0);
    imem[3]  = enc_r(4, 1, 2, 0, 1);
    imem[4]  = enc_r(7, 1, 2, 0, 2);
    imem[5]  = enc_r(8, 1, 2, 0, 3);
    imem[6]  = enc_r(9, 4, 0, 4, 4);
    imem[7]  = enc_r(10, 4, 0, 1, 5);
    imem[8]  = enc_i(OpSw, 3, 0, 100);
    imem[9]  = enc_i(OpSw, 4, 0, 101);
    imem[10] = enc_i(OpSw, 7, 0, 102);
    imem[11] = enc_i(OpSw, 8, 0, 103);
    imem[12] = enc_i(OpSw, 9, 0, 104);
    imem[13] = enc_i(OpSw, 10, 0, 105);
    imem[14] = enc_r(1, 2, 2, 0, 6);
    imem[15] = enc_i(OpSw, 1, 0, 106);
    imem[16] = enc_j(OpJ, 16);
    addr = '{100, 101, 102, 103, 104, 105, 106};
    want = '{32'd12, 32'hFFFF_FFFE, 32'd5, 32'd7, 32'hFFFF_FFE0, 32'hFFFF_FFFF, 32'd5};
    do_reset();
    step(20);
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if (dmem[addr[i]] !== want[i]) begin
        n_fail++;
        $display("FAIL arith[%0d]: got %h, want %h", i, dmem[addr[i]], want[i]);
      end
    end
  endtask

  task automatic test_overflow();
    int          addr [10];
    logic [31:0] want [10];
    clear_imem();
    imem[0]  = enc_i(OpAddi, 1, 0, 1);
    imem[1]  = enc_r(1, 1, 0, 30, 4);
    imem[2]  = enc_i(OpAddi, 14, 1, -1);
    imem[3]  = enc_r(1, 1, 14, 0, 0);
    imem[4]  = enc_i(OpAddi, 5, 0, 77);
    imem[5]  = enc_r(5, 1, 1, 0, 0);
    imem[6]  = enc_i(OpSw, 5, 0, 110);
    imem[7]  = enc_i(OpSw, 30, 0, 111);
    imem[8]  = enc_i(OpAddi, 6, 1, 1);
    imem[9]  = enc_i(OpSw, 30, 0, 112);
    imem[10] = enc_i(OpSw, 6, 0, 113);
    imem[11] = enc_i(OpAddi, 15, 0, -1);
    imem[12] = enc_r(7, 1, 15, 0, 1);
    imem[13] = enc_i(OpSw, 30, 0, 114);
    imem[14] = enc_i(OpSw, 7, 0, 115);
    imem[15] = enc_i(OpSw, 1, 0, 116);
    imem[16] = enc_r(16, 1, 15, 0, 0);
    imem[17] = enc_i(OpSw, 30, 0, 117);
    imem[18] = enc_r(0, 1, 1, 0, 0);
    imem[19] = enc_i(OpSw, 30, 0, 118);
    imem[20] = enc_i(OpSw, 16, 0, 119);
    imem[21] = enc_j(OpJ, 21);
    addr = '{110, 111, 112, 113, 114, 115, 116, 117, 118, 119};
    want = '{32'd77, 32'd1, 32'd2, 32'd0, 32'd3, 32'd0, 32'h7FFF_FFFF, 32'd3, 32'd3,
             32'h7FFF_FFFE};
    do_reset();
    step(25);
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (dmem[addr[i]] !== want[i]) begin
        n_fail++;
        $display("FAIL overflow[%0d]: got %h, want %h", i, dmem[addr[i]], want[i]);
      end
    end
  endtask

  task automatic test_mem();
    clear_imem();
    imem[0]  = enc_i(OpAddi, 3, 0, 12);
    imem[1]  = enc_i(OpSw, 3, 0, 4);
    imem[2]  = enc_i(OpLw, 6, 0, 4);
    imem[3]  = enc_i(OpSw, 6, 0, 5);
    imem[4]  = enc_i(OpAddi, 8, 0, 2);
    imem[5]  = enc_i(OpLw, 9, 8, 3);
    imem[6]  = enc_i(OpSw, 9, 0, 7);
    imem[7]  = enc_i(OpAddi, 10, 0, 55);
    imem[8]  = enc_i(OpSw, 10, 0, 8);
    imem[9]  = enc_i(OpAddi, 0, 0, 5);
    imem[10] = enc_i(OpSw, 0, 0, 8);
    imem[11] = enc_j(OpJ, 11);
    do_reset();
    n_cmp++;
    if (bus.wren !== 1'b0) begin
      n_fail++;
      $display("FAIL mem_wren_idle: got %b, want 0", bus.wren);
    end
    step(1);
    n_cmp++;
    if ({bus.wren, bus.address_dmem, bus.data} !== {1'b1, 12'd4, 32'd12}) begin
      n_fail++;
      $display("FAIL mem_sw_port: got wren %b addr %0d data %h, want 1 4 0000000c",
               bus.wren, bus.address_dmem, bus.data);
    end
    step(1);
    n_cmp++;
    if ({bus.wren, bus.address_dmem} !== {1'b0, 12'd4}) begin
      n_fail++;
      $display("FAIL mem_lw_port: got wren %b addr %0d, want 0 4", bus.wren, bus.address_dmem);
    end
    step(12);
    n_cmp++;
    if (dmem[5] !== 32'd12) begin
      n_fail++;
      $display("FAIL mem_lw_value: got %h, want 0000000c", dmem[5]);
    end
    n_cmp++;
    if (dmem[7] !== 32'd12) begin
      n_fail++;
      $display("FAIL mem_lw_base: got %h, want 0000000c", dmem[7]);
    end
    n_cmp++;
    if (dmem[8] !== 32'd0) begin
      n_fail++;
      $display("FAIL mem_r0_write: got %h, want 00000000", dmem[8]);
    end
  endtask

  task automatic test_branch();
    logic [11:0] pcs [17];
    logic [31:0] want [5];
    clear_imem();
    imem[0]  = enc_i(OpAddi, 1, 0, -1);
    imem[1]  = enc_i(OpAddi, 2, 0, 1);
    imem[2]  = enc_i(OpBne, 1, 2, 2);
    imem[3]  = enc_i(OpAddi, 20, 0, 1);
    imem[4]  = enc_i(OpAddi, 20, 0, 1);
    imem[5]  = enc_i(OpBlt, 1, 2, 1);
    imem[6]  = enc_i(OpAddi, 21, 0, 1);
    imem[7]  = enc_i(OpBlt, 2, 1, 1);
    imem[8]  = enc_i(OpAddi, 22, 0, 1);
    imem[9]  = enc_i(OpBne, 1, 1, 1);
    imem[10] = enc_i(OpAddi, 23, 0, 1);
    imem[11] = enc_i(OpBlt, 1, 1, 1);
    imem[12] = enc_i(OpAddi, 24, 0, 1);
    for (int i = 0; i < 5; i++) imem[13 + i] = enc_i(OpSw, 20 + i, 0, 120 + i);
    imem[18] = enc_j(OpJ, 18);
    pcs  = '{12'd0, 12'd1, 12'd2, 12'd5, 12'd7, 12'd8, 12'd9, 12'd10, 12'd11, 12'd12, 12'd13,
             12'd14, 12'd15, 12'd16, 12'd17, 12'd18, 12'd18};
    want = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd1};
    do_reset();
    for (int i = 0; i < 17; i++) begin
      n_cmp++;
      if (bus.address_imem !== pcs[i]) begin
        n_fail++;
        $display("FAIL branch_pc[%0d]: got %0d, want %0d", i, bus.address_imem, pcs[i]);
      end
      step(1);
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (dmem[120 + i] !== want[i]) begin
        n_fail++;
        $display("FAIL branch_reg[%0d]: got %h, want %h", i, dmem[120 + i], want[i]);
      end
    end
  endtask

  task automatic test_jump();
    logic [11:0] pcs [13];
    logic [31:0] want [3];
    clear_imem();
    imem[0]  = enc_i(OpAddi, 1, 0, 3);
    imem[1]  = enc_j(OpJal, 20);
    imem[2]  = enc_j(OpSetx, 9);
    imem[3]  = enc_j(OpBex, 30);
    imem[20] = enc_i(OpSw, 31, 0, 130);
    imem[21] = enc_i(OpJr, 31, 0, 0);
    imem[30] = enc_i(OpSw, 30, 0, 131);
    imem[31] = enc_j(OpSetx, 0);
    imem[32] = enc_j(OpBex, 40);
    imem[33] = enc_i(OpAddi, 25, 0, 1);
    imem[34] = enc_i(OpSw, 25, 0, 132);
    imem[35] = enc_j(OpJ, 35);
    imem[40] = enc_i(OpAddi, 25, 0, 7);
    imem[41] = enc_j(OpJ, 41);
    pcs  = '{12'd0, 12'd1, 12'd20, 12'd21, 12'd2, 12'd3, 12'd30, 12'd31, 12'd32, 12'd33,
             12'd34, 12'd35, 12'd35};
    want = '{32'd2, 32'd9, 32'd1};
    do_reset();
    for (int i = 0; i < 13; i++) begin
      n_cmp++;
      if (bus.address_imem !== pcs[i]) begin
        n_fail++;
        $display("FAIL jump_pc[%0d]: got %0d, want %0d", i, bus.address_imem, pcs[i]);
      end
      step(1);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (dmem[130 + i] !== want[i]) begin
        n_fail++;
        $display("FAIL jump_reg[%0d]: got %h, want %h", i, dmem[130 + i], want[i]);
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b0;
    test_reset();
    test_arith();
    test_overflow();
    test_mem();
    test_branch();
    test_jump();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
